// File: rtl/conv_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_enc_ctrl
// Purpose  : Frame controller for an external K=3 rate-1/2 convolutional
//            encoder. Buffers a frame, feeds it bit-serially, then flushes.
// Revision : 1.0
// ============================================================================
module conv_enc_ctrl #(
   parameter int FRAME_MAX = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] frame_len,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       enc_rst,
   output logic       enc_bit,
   input  logic [1:0] enc_code,
   output logic [1:0] out_code,
   output logic       out_valid,
   output logic       out_last,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [6:0] c_MAX_LEN = 7'(FRAME_MAX);
   localparam int         c_IW      = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LOAD   = 3'd2,
      S_ENCODE = 3'd3,
      S_TAIL   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [5:0]           r_cnt;
   logic [5:0]           w_cnt_nxt;
   logic [5:0]           r_len;
   logic [FRAME_MAX-1:0] r_buf;
   logic [c_IW-1:0]      w_idx;
   logic                 w_len_ok;
   logic                 w_cnt_last;
   logic                 w_len_ld;
   logic                 w_wr;
   logic                 w_sym;
   logic                 w_last;
   logic                 w_err;
   logic                 w_in_ready;
   logic                 w_enc_rst;
   logic                 w_enc_bit;
   logic [1:0]           r_out_code;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic                 r_err;

   assign w_idx      = r_cnt[c_IW-1:0];
   assign w_cnt_last = (r_cnt == (r_len - 6'd1));
   assign w_len_ok   = (frame_len != 6'd0) && ({1'b0, frame_len} <= c_MAX_LEN);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_ld    = 1'b0;
      w_wr        = 1'b0;
      w_sym       = 1'b0;
      w_last      = 1'b0;
      w_err       = 1'b0;
      w_in_ready  = 1'b0;
      w_enc_rst   = 1'b0;
      w_enc_bit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_len_ok) begin
                  w_len_ld    = 1'b1;
                  w_cnt_nxt   = 6'd0;
                  w_state_nxt = S_CLEAR;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            w_enc_rst   = 1'b1;
            w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_wr = 1'b1;
               if (w_cnt_last) begin
                  w_cnt_nxt   = 6'd0;
                  w_state_nxt = S_ENCODE;
               end else begin
                  w_cnt_nxt = r_cnt + 6'd1;
               end
            end
         end
         S_ENCODE: begin
            w_enc_bit = r_buf[w_idx];
            w_sym     = 1'b1;
            if (w_cnt_last) begin
               w_cnt_nxt   = 6'd0;
               w_state_nxt = S_TAIL;
            end else begin
               w_cnt_nxt = r_cnt + 6'd1;
            end
         end
         S_TAIL: begin
            // two zero bits flush the K=3 shift register
            w_sym = 1'b1;
            if (r_cnt == 6'd1) begin
               w_last      = 1'b1;
               w_cnt_nxt   = 6'd0;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 6'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 6'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 6'd0;
         r_len       <= 6'd0;
         r_out_code  <= 2'b00;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_valid <= w_sym;
         r_out_last  <= w_last;
         r_err       <= w_err;
         if (w_len_ld) begin
            r_len <= frame_len;
         end
         if (w_sym) begin
            r_out_code <= enc_code;
         end
      end
   end

   // Frame storage carries no reset: contents are rewritten before every use.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_buf[w_idx] <= in_bit;
      end
   end

   assign in_ready  = w_in_ready;
   assign enc_rst   = w_enc_rst;
   assign enc_bit   = w_enc_bit;
   assign out_code  = r_out_code;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign done      = r_out_last;
   assign err       = r_err;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_enc_ctrl
// Purpose  : Scoreboard bench for conv_enc_ctrl with an attached K=3 encoder.
// Revision : 1.0
// ============================================================================
module tb_conv_enc_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [5:0] frame_len = 6'd0;
   logic       in_bit = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       enc_rst;
   logic       enc_bit;
   logic [1:0] enc_code;
   logic [1:0] out_code;
   logic       out_valid;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       err;

   int         n_chk = 0;
   int         n_err = 0;
   int         err_seen = 0;
   logic [2:0] sb[$];
   logic [2:0] e;
   logic       in_frame = 1'b0;
   logic       s1;
   logic       s2;

   conv_enc_ctrl #(.FRAME_MAX(32)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .frame_len (frame_len),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .enc_rst   (enc_rst),
      .enc_bit   (enc_bit),
      .enc_code  (enc_code),
      .out_code  (out_code),
      .out_valid (out_valid),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // external encoder: g111 / g101, shares rst, cleared by enc_rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else if (enc_rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= enc_bit;
         s2 <= s1;
      end
   end
   assign enc_code = {enc_bit ^ s1 ^ s2, enc_bit ^ s2};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_exp(input int len, input logic [31:0] bits);
      logic a1, a2, b;
      a1 = 1'b0;
      a2 = 1'b0;
      for (int i = 0; i < len + 2; i++) begin
         b = (i < len) ? bits[i] : 1'b0;
         sb.push_back({(i == len + 1), b ^ a1 ^ a2, b ^ a2});
         a2 = a1;
         a1 = b;
      end
   endtask

   always @(negedge clk) begin
      if (err) err_seen++;
      if (rst) begin
         in_frame = 1'b0;
      end else begin
         if (in_frame) chk("valid_gap", out_valid, 1);
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", out_valid, 0);
            end else begin
               e = sb.pop_front();
               chk("code", out_code, e[1:0]);
               chk("last", out_last, e[2]);
               chk("done", done, e[2]);
            end
            in_frame = !out_last;
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic run_frame(input int len, input logic [31:0] bits, input bit gaps,
                            input bit busy_start, input int abort_n);
      int i, k, first, nsym, guard, err0;
      err0 = err_seen;
      push_exp(len, bits);
      start     = 1'b1;
      frame_len = 6'(len);
      @(negedge clk);
      start = 1'b0;
      chk("clear_rst", enc_rst, 1);
      chk("clear_busy", busy, 1);
      chk("clear_rdy", in_ready, 0);
      i = 0;
      guard = 0;
      while (i < len && guard < 2000) begin
         in_bit   = bits[i];
         in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (busy_start) begin
            start     = ($urandom_range(0, 3) == 0);
            frame_len = (guard % 2 == 1) ? 6'd0 : 6'd5;
         end
         if (in_valid && in_ready) i++;
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < len) chk("load_timeout", i, len);
      chk("encode_rdy", in_ready, 0);
      k = 1;
      first = -1;
      nsym = 0;
      while (k < len + 12) begin
         if (out_valid) begin
            nsym++;
            if (first < 0) first = k;
         end
         if (done) break;
         if (abort_n > 0 && nsym == abort_n) begin
            #2 rst = 1'b1;
            #1 chk("rst_outputs", {in_ready, enc_rst, enc_bit, out_code, out_valid,
                                   out_last, busy, done, err}, 0);
            @(negedge clk);
            #2 sb.delete();
            rst = 1'b0;
            return;
         end
         if (busy_start) begin
            start     = (k % 3 == 0);
            frame_len = (k % 2 == 1) ? 6'd0 : 6'd5;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk("first_lat", first, 2);
      chk("done_lat", k, len + 3);
      chk("nsym", nsym, len + 2);
      chk("done_idle", busy, 0);
      if (busy_start) chk("busy_err", err_seen - err0, 0);
   endtask

   task automatic bad_start(input int len);
      start     = 1'b1;
      frame_len = 6'(len);
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_busy2", busy, 0);
   endtask

   initial begin
      #1 chk("reset_outputs", {in_ready, enc_rst, enc_bit, out_code, out_valid,
                               out_last, busy, done, err}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_frame(4, 32'hD, 1'b0, 1'b0, 0);
      repeat (2) @(negedge clk);

      run_frame(1, 32'h1, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk("len1_busy_after", busy, 0);

      bad_start(0);
      bad_start(33);
      repeat (2) @(negedge clk);

      run_frame(32, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
      repeat (2) @(negedge clk);

      run_frame(8, 32'hA5, 1'b0, 1'b0, 3);
      repeat (3) @(negedge clk);
      chk("abort_idle", busy, 0);
      chk("abort_novalid", out_valid, 0);
      run_frame(4, 32'hD, 1'b0, 1'b0, 0);
      repeat (2) @(negedge clk);

      run_frame(5, 32'h13, 1'b0, 1'b0, 0);
      run_frame(4, 32'hD, 1'b0, 1'b0, 0);
      run_frame(6, 32'h2B, 1'b1, 1'b0, 0);

      repeat (4) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
